// File: rtl/master_rx_deser.sv
// Read-phase deserialiser: waits for a start bit, shifts DATA_WIDTH bits LSB first and holds the word for a ready/valid consumer.
// Define MASTER_RX_PARITY_EN to append and check one even-parity bit per frame.
module master_rx_deser #(
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_en,
  input  logic                  master_rx,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rx_busy,
  output logic                  overrun_err,
  output logic                  timeout_err,
  output logic                  parity_err
);

  localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [5:0] BIT_LAST   = 6'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    SHIFT      = 3'd2,
`ifdef MASTER_RX_PARITY_EN
    PARITY     = 3'd4,
`endif
    DONE       = 3'd3
  } state_t;

  state_t                state_r, state_nxt;
  logic [7:0]            start_cnt_r, start_cnt_nxt;
  logic [5:0]            bit_cnt_r, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shift_r, shift_nxt, shift_ins;
  logic [DATA_WIDTH-1:0] rd_data_r, rd_data_nxt;
  logic                  rd_valid_r, rd_valid_nxt;
  logic                  overrun_r, overrun_nxt;
  logic                  timeout_r, timeout_nxt;

`ifdef MASTER_RX_PARITY_EN
  logic                  perr_r, perr_nxt;

  // Odd count of ones over data plus parity bit means the even-parity check failed.
  function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign overrun_err = overrun_r;
  assign timeout_err = timeout_r;
  assign rx_busy     = (state_r != IDLE);

  // Current serial bit dropped into the shift register at the bit-counter position.
  always_comb begin
    shift_ins = shift_r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_cnt_r == 6'(i)) shift_ins[i] = master_rx;
      else                    shift_ins[i] = shift_r[i];
    end
  end

  // Next-state and next-register values for the frame FSM and the output holding stage.
  always_comb begin
    state_nxt     = state_r;
    start_cnt_nxt = start_cnt_r;
    bit_cnt_nxt   = bit_cnt_r;
    shift_nxt     = shift_r;
    rd_data_nxt   = rd_data_r;
    rd_valid_nxt  = rd_valid_r;
    overrun_nxt   = overrun_r;
    timeout_nxt   = 1'b0;
`ifdef MASTER_RX_PARITY_EN
    perr_nxt      = 1'b0;
`endif
    if (rd_valid_r && rd_ready) rd_valid_nxt = 1'b0;
    else                        rd_valid_nxt = rd_valid_r;

    case (state_r)
      IDLE: begin
        if (rx_en) begin
          state_nxt     = WAIT_START;
          start_cnt_nxt = 8'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_START: begin
        if (!rx_en) begin
          state_nxt = IDLE;
        end else if (master_rx) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = 6'd0;
          shift_nxt   = {DATA_WIDTH{1'b0}};
        end else if (start_cnt_r == START_LAST) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          start_cnt_nxt = start_cnt_r + 8'd1;
        end
      end
      SHIFT: begin
        if (!rx_en) begin
          state_nxt = IDLE;
        end else begin
          shift_nxt = shift_ins;
          if (bit_cnt_r == BIT_LAST) begin
`ifdef MASTER_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = DONE;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt_r + 6'd1;
          end
        end
      end
`ifdef MASTER_RX_PARITY_EN
      PARITY: begin
        if (!rx_en) begin
          state_nxt = IDLE;
        end else if (parity_bad(shift_r, master_rx)) begin
          state_nxt = IDLE;
          perr_nxt  = 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        // A word still held and not taken this cycle wins; the new one is lost.
        if (!rd_valid_r || rd_ready) begin
          rd_data_nxt  = shift_r;
          rd_valid_nxt = 1'b1;
        end else begin
          overrun_nxt = 1'b1;
        end
        start_cnt_nxt = 8'd0;
        if (rx_en) state_nxt = WAIT_START;
        else       state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      start_cnt_r <= 8'd0;
      bit_cnt_r   <= 6'd0;
      shift_r     <= {DATA_WIDTH{1'b0}};
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      rd_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      timeout_r   <= 1'b0;
`ifdef MASTER_RX_PARITY_EN
      perr_r      <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt;
      start_cnt_r <= start_cnt_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      shift_r     <= shift_nxt;
      rd_data_r   <= rd_data_nxt;
      rd_valid_r  <= rd_valid_nxt;
      overrun_r   <= overrun_nxt;
      timeout_r   <= timeout_nxt;
`ifdef MASTER_RX_PARITY_EN
      perr_r      <= perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_master_rx_deser.sv
// Directed bench for master_rx_deser (DATA_WIDTH=8, START_TIMEOUT=4) with a frame-level reference model checked every cycle.
module tb_master_rx_deser;

  localparam int DW = 8;
  localparam int TO = 4;
`ifdef MASTER_RX_PARITY_EN
  localparam int FRAME_BITS = DW + 1;
`else
  localparam int FRAME_BITS = DW;
`endif

  logic          clk;
  logic          rstn;
  logic          rx_en;
  logic          master_rx;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rx_busy;
  logic          overrun_err;
  logic          timeout_err;
  logic          parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  master_rx_deser #(.DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .rx_en(rx_en), .master_rx(master_rx), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rx_busy(rx_busy),
    .overrun_err(overrun_err), .timeout_err(timeout_err), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a receiver described as "listening / collecting bits / delivering".
  bit          m_ready   = 1'b0;
  bit          m_active  = 1'b0;
  bit          m_started = 1'b0;
  bit          m_deliver = 1'b0;
  int          m_wait    = 0;
  bit          m_bits[$];
  logic [DW-1:0] m_word  = '0;
  logic [DW-1:0] m_data  = '0;
  bit          m_valid   = 1'b0;
  bit          m_overrun = 1'b0;
  bit          m_timeout = 1'b0;
  bit          m_perr    = 1'b0;

  task automatic model_step();
    bit nv, tp, pp, ok;
    int ones;
    logic [DW-1:0] w;
    if (!rstn) begin
      m_ready = 1'b1; m_active = 1'b0; m_started = 1'b0; m_deliver = 1'b0; m_wait = 0;
      m_bits.delete(); m_data = '0; m_valid = 1'b0; m_overrun = 1'b0;
      m_timeout = 1'b0; m_perr = 1'b0;
      return;
    end
    tp = 1'b0; pp = 1'b0;
    nv = m_valid && !rd_ready;
    if (m_deliver) begin
      if (!m_valid || rd_ready) begin
        m_data = m_word; nv = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
      m_deliver = 1'b0; m_active = rx_en; m_started = 1'b0; m_wait = 0;
    end else if (m_active) begin
      if (!rx_en) begin
        m_active = 1'b0; m_started = 1'b0;
      end else if (!m_started) begin
        if (master_rx) begin
          m_started = 1'b1; m_bits.delete();
        end else if (m_wait == TO - 1) begin
          tp = 1'b1; m_active = 1'b0;
        end else begin
          m_wait++;
        end
      end else begin
        m_bits.push_back(master_rx);
        if (m_bits.size() == FRAME_BITS) begin
          ones = 0;
          for (int i = 0; i < FRAME_BITS; i++) ones += int'(m_bits[i]);
          w = '0;
          for (int i = 0; i < DW; i++) w[i] = m_bits[i];
          ok = (ones % 2 == 0) || (FRAME_BITS == DW);
          m_active = 1'b0; m_started = 1'b0;
          if (ok) begin
            m_word = w; m_deliver = 1'b1;
          end else begin
            pp = 1'b1;
          end
        end
      end
    end else if (rx_en) begin
      m_active = 1'b1; m_started = 1'b0; m_wait = 0;
    end
    m_valid = nv; m_timeout = tp; m_perr = pp;
  endtask

  // Compare process: advance the model on each rising edge, check every output just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_ready) begin
        check("cyc_rd_data",  32'(rd_data),     32'(m_data));
        check("cyc_rd_valid", 32'(rd_valid),    32'(m_valid));
        check("cyc_rx_busy",  32'(rx_busy),     32'(m_active || m_deliver));
        check("cyc_overrun",  32'(overrun_err), 32'(m_overrun));
        check("cyc_timeout",  32'(timeout_err), 32'(m_timeout));
        check("cyc_parity",   32'(parity_err),  32'(m_perr));
      end
    end
  end

  task automatic step(input logic en, input logic b, input logic rdy);
    rx_en = en; master_rx = b; rd_ready = rdy;
    @(negedge clk);
  endtask

  // Start bit, data bits, optional parity bit, then the DONE cycle.
  task automatic send_frame(input logic [DW-1:0] w, input logic pbit, input logic rdy, input logic done_rdy);
    step(1'b1, 1'b1, rdy);
    for (int i = 0; i < DW; i++) step(1'b1, w[i], rdy);
`ifdef MASTER_RX_PARITY_EN
    step(1'b1, pbit, rdy);
`else
    if (pbit === 1'bx) $display("note: unexpected X parity bit");
`endif
    step(1'b1, 1'b0, done_rdy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w;
    rstn = 1'b0; rx_en = 1'b0; master_rx = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_rd_data",  32'(rd_data),  32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rx_busy",  32'(rx_busy),  32'h0);
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b1);

    // Basic 0xA5: ten edges from start bit to rd_valid (eleven with parity).
    w = 8'hA5;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < DW; i++) step(1'b1, w[i], 1'b1);
`ifdef MASTER_RX_PARITY_EN
    step(1'b1, 1'b0, 1'b1);
`endif
    check("basic_valid_early", 32'(rd_valid), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    check("basic_valid", 32'(rd_valid), 32'h1);
    check("basic_data",  32'(rd_data),  32'hA5);
    step(1'b0, 1'b0, 1'b1);
    check("basic_valid_1clk", 32'(rd_valid), 32'h0);

    // Load in the same DONE cycle as the consumer takes the old word.
    step(1'b1, 1'b0, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b0, 1'b0);
    check("simul_first", 32'(rd_data), 32'h11);
    send_frame(8'h5A, ^8'h5A, 1'b0, 1'b1);
    check("simul_valid",   32'(rd_valid),    32'h1);
    check("simul_data",    32'(rd_data),     32'h5A);
    check("simul_overrun", 32'(overrun_err), 32'h0);

    // Held word survives rx_en toggling.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("hold_valid", 32'(rd_valid), 32'h1);
    check("hold_data",  32'(rd_data),  32'h5A);
    step(1'b0, 1'b0, 1'b1);
    check("hold_taken", 32'(rd_valid), 32'h0);

    // Start timeout: pulse after the fourth idle WAIT_START cycle.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < TO - 1; i++) step(1'b1, 1'b0, 1'b1);
    check("to_not_yet", 32'(timeout_err), 32'h0);
    check("to_busy",    32'(rx_busy),     32'h1);
    step(1'b1, 1'b0, 1'b1);
    check("to_pulse", 32'(timeout_err), 32'h1);
    check("to_idle",  32'(rx_busy),     32'h0);
    check("to_valid", 32'(rd_valid),    32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("to_cleared", 32'(timeout_err), 32'h0);

    // Abort after four data bits.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("abort_idle", 32'(rx_busy), 32'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    check("abort_no_valid", 32'(rd_valid), 32'h0);

    // Overrun with back-to-back frames and no consumer.
    step(1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
    check("ovr_first", 32'(rd_data), 32'h3C);
    send_frame(8'hC3, ^8'hC3, 1'b0, 1'b0);
    check("ovr_data",  32'(rd_data),     32'h3C);
    check("ovr_flag",  32'(overrun_err), 32'h1);
    check("ovr_valid", 32'(rd_valid),    32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("ovr_taken",  32'(rd_valid),    32'h0);
    check("ovr_sticky", 32'(overrun_err), 32'h1);

`ifdef MASTER_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is correct, 0 is not.
    step(1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_ok_data",  32'(rd_data),  32'h07);
    check("par_ok_valid", 32'(rd_valid), 32'h1);
    w = 8'h07;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < DW; i++) step(1'b1, w[i], 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("par_err_pulse", 32'(parity_err), 32'h1);
    check("par_err_valid", 32'(rd_valid),   32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("par_err_clear", 32'(parity_err), 32'h0);
`endif

    // Reset in the middle of a frame while a word is held.
    step(1'b1, 1'b0, 1'b0);
    send_frame(8'hE7, ^8'hE7, 1'b0, 1'b0);
    check("pre_rst_data", 32'(rd_data), 32'hE7);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    check("mid_rst_data",    32'(rd_data),     32'h0);
    check("mid_rst_valid",   32'(rd_valid),    32'h0);
    check("mid_rst_busy",    32'(rx_busy),     32'h0);
    check("mid_rst_overrun", 32'(overrun_err), 32'h0);
    check("mid_rst_timeout", 32'(timeout_err), 32'h0);
    check("mid_rst_parity",  32'(parity_err),  32'h0);
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("post_rst_busy", 32'(rx_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
